// File: rtl/cnn_pkg.sv
// Shared types and helpers for the convolution window scheduler and its address generator.
package cnn_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_K          = 3;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        MAC_WAIT,
        OUTPUT,
        FIN
    } state_t;

    // Row-major pixel address of tap (kr, kc) of the window whose top-left is (row, col).
    function automatic int unsigned win_addr(
        input int unsigned row,
        input int unsigned col,
        input int unsigned kr,
        input int unsigned kc,
        input int unsigned width
    );
        return (row + kr) * width + (col + kc);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window position (row/col) and tap (kr/kc) counters plus the memory address adder.
module conv_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int K          = DEF_K,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  tap_step,
    input  logic                  win_step,
    output logic [7:0]            row,
    output logic [7:0]            col,
    output logic [7:0]            tap,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last_tap,
    output logic                  last_win
);

    localparam logic [7:0] KC_LAST  = 8'(K - 1);
    localparam logic [7:0] TAP_LAST = 8'(K * K - 1);
    localparam logic [7:0] ROW_LAST = 8'(IMG_H - K);
    localparam logic [7:0] COL_LAST = 8'(IMG_W - K);

    logic [7:0] kr;
    logic [7:0] kc;

    assign last_tap = (tap == TAP_LAST);
    assign last_win = (row == ROW_LAST) && (col == COL_LAST);
    assign addr     = ADDR_WIDTH'(win_addr(32'(row), 32'(col), 32'(kr), 32'(kc), 32'(IMG_W)));

    // The final window holds its position so the last result keeps reporting it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row <= '0;
            col <= '0;
            tap <= '0;
            kr  <= '0;
            kc  <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
            tap <= '0;
            kr  <= '0;
            kc  <= '0;
        end else begin
            if (tap_step) begin
                if (last_tap) begin
                    tap <= '0;
                    kr  <= '0;
                    kc  <= '0;
                end else begin
                    tap <= tap + 8'd1;
                    if (kc == KC_LAST) begin
                        kc <= '0;
                        kr <= kr + 8'd1;
                    end else begin
                        kc <= kc + 8'd1;
                    end
                end
            end
            if (win_step && !last_win) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_window_scheduler.sv
// Walks a KxK window over the feature map, feeds the MAC and streams results out.
// Define CONV_SCHED_RELU_EN to zero results whose MSB is set when they are captured.
module conv_window_scheduler
    import cnn_pkg::*;
#(
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8,
    parameter int K          = DEF_K,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = 6,
    parameter int MAC_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    mem_rd_en,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]   mem_rd_data,
    output logic [K*K*DATA_WIDTH-1:0] win_data,
    output logic                    win_valid,
    input  logic [DATA_WIDTH-1:0]   mac_result,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_data,
    output logic [7:0]              out_row,
    output logic [7:0]              out_col
);

    state_t                state;
    logic                  cap_valid;
    logic [7:0]            cap_idx;
    logic [7:0]            lat_cnt;
    logic [7:0]            row;
    logic [7:0]            col;
    logic [7:0]            tap;
    logic                  last_tap;
    logic                  last_win;
    logic                  clear;
    logic                  tap_step;
    logic                  win_step;
    logic [DATA_WIDTH-1:0] result_d;

    assign clear    = (state == IDLE) && start;
    assign tap_step = (state == FETCH) && mem_rd_en;
    assign win_step = (state == OUTPUT) && out_ready;

`ifdef CONV_SCHED_RELU_EN
    assign result_d = mac_result[DATA_WIDTH-1] ? '0 : mac_result;
`else
    assign result_d = mac_result;
`endif

    conv_addr_gen #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .K          (K),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .tap_step (tap_step),
        .win_step (win_step),
        .row      (row),
        .col      (col),
        .tap      (tap),
        .addr     (mem_rd_addr),
        .last_tap (last_tap),
        .last_win (last_win)
    );

    // Read data arrives one cycle after its strobe, so the tap index is delayed to match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            win_data  <= '0;
            win_valid <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
            cap_valid <= 1'b0;
            cap_idx   <= '0;
            lat_cnt   <= '0;
        end else begin
            done      <= 1'b0;
            cap_valid <= tap_step;
            cap_idx   <= tap;
            for (int t = 0; t < K * K; t++) begin
                if (cap_valid && (cap_idx == 8'(t))) begin
                    win_data[t*DATA_WIDTH +: DATA_WIDTH] <= mem_rd_data;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FETCH;
                        busy      <= 1'b1;
                        mem_rd_en <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_rd_en) begin
                        if (last_tap) begin
                            mem_rd_en <= 1'b0;
                        end
                    end else begin
                        state     <= MAC_WAIT;
                        win_valid <= 1'b1;
                        lat_cnt   <= '0;
                    end
                end
                MAC_WAIT: begin
                    if (lat_cnt == 8'(MAC_LAT - 1)) begin
                        out_data  <= result_d;
                        out_row   <= row;
                        out_col   <= col;
                        out_valid <= 1'b1;
                        win_valid <= 1'b0;
                        state     <= OUTPUT;
                    end else begin
                        lat_cnt <= lat_cnt + 8'd1;
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (last_win) begin
                            state <= FIN;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= FETCH;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
